// File: rtl/demux_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_sched_pkg
// Description : Shared types and constants for the demux burst scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_sched_pkg;

    localparam int NUM_SINKS = 4;
    localparam int SEL_W     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Round-robin picker; first eligible sink after 'last', wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
    import demux_sched_pkg::*;
(
    input  logic [NUM_SINKS-1:0] elig,
    input  logic [SEL_W-1:0]     last,
    output logic [SEL_W-1:0]     grant,
    output logic                 found
);

    logic [SEL_W-1:0] w_idx;

    // Offset 4 wraps back onto 'last' itself, so it is considered last.
    always_comb begin
        grant = '0;
        found = 1'b0;
        w_idx = '0;
        for (int i = 1; i <= NUM_SINKS; i++) begin
            w_idx = last + SEL_W'(i);
            if (!found && elig[w_idx]) begin
                grant = w_idx;
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/demux_sched.sv
`default_nettype none
// ============================================================================
// Module      : demux_sched
// Description : Round-robin burst scheduler driving a 1-to-4 demux tree.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_sched
    import demux_sched_pkg::*;
#(
    parameter int DW    = 8,
    parameter int BURST = 4,
    parameter int CW    = 4
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [DW-1:0]        IN_DATA,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [NUM_SINKS-1:0] SINK_MASK,
    input  logic [NUM_SINKS-1:0] SINK_READY,
    output logic [SEL_W-1:0]     SEL,
    output logic                 EN,
    output logic [DW-1:0]        OUT_DATA,
    output logic [NUM_SINKS-1:0] OUT_VALID,
    output logic                 BUSY
);

    localparam logic [CW-1:0] c_last_cnt = CW'(BURST - 1);
    localparam logic [CW-1:0] c_one      = CW'(1);

    state_t               r_state;
    logic [SEL_W-1:0]     r_sel;
    logic [SEL_W-1:0]     r_last;
    logic [CW-1:0]        r_cnt;
    logic                 r_en;

    logic [NUM_SINKS-1:0] w_elig;
    logic [SEL_W-1:0]     w_grant;
    logic                 w_found;
    logic                 w_in_xfer;
    logic                 w_sel_mask;
    logic                 w_sel_ready;
    logic                 w_transfer;

    assign w_elig      = SINK_MASK & SINK_READY;
    assign w_in_xfer   = RSTN && (r_state == XFER);
    assign w_sel_mask  = SINK_MASK[r_sel];
    assign w_sel_ready = SINK_READY[r_sel];
    assign w_transfer  = IN_VALID && IN_READY;

    rr_pick4 u_pick (
        .elig  (w_elig),
        .last  (r_last),
        .grant (w_grant),
        .found (w_found)
    );

    // Handshake outputs are gated by RSTN so nothing leaks during reset.
    assign IN_READY = w_in_xfer && w_sel_mask && w_sel_ready;
    assign BUSY     = RSTN && (r_state != IDLE);
    assign OUT_DATA = IN_DATA;
    assign SEL      = r_sel;
    assign EN       = r_en;

    always_comb begin
        OUT_VALID = '0;
        if (w_in_xfer && IN_VALID && w_sel_mask) begin
            OUT_VALID[r_sel] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_last  <= 2'd3;
            r_cnt   <= '0;
            r_en    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (IN_VALID) begin
                        r_state <= ARB;
                    end
                end
                ARB: begin
                    // Losing the source wins over a pending grant.
                    if (!IN_VALID) begin
                        r_state <= IDLE;
                    end else if (w_found) begin
                        r_sel   <= w_grant;
                        r_last  <= w_grant;
                        r_cnt   <= '0;
                        r_en    <= 1'b1;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (!w_sel_mask) begin
                        r_state <= ARB;
                        r_en    <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_transfer) begin
                        if (r_cnt == c_last_cnt) begin
                            r_state <= ARB;
                            r_en    <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_one;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_sched
// Description : Self-checking bench for demux_sched against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_sched;

    localparam int DW    = 8;
    localparam int BURST = 4;
    localparam int P_IDLE  = 0;
    localparam int P_ARB   = 1;
    localparam int P_GRANT = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [3:0]    mask = 4'hF;
    logic [3:0]    ready = 4'hF;
    logic          in_ready;
    logic [1:0]    sel;
    logic          en;
    logic [DW-1:0] out_data;
    logic [3:0]    out_valid;
    logic          busy;

    always #5 clk = ~clk;

    demux_sched #(.DW(DW), .BURST(BURST), .CW(4)) dut (
        .CLK        (clk),
        .RSTN       (rstn),
        .IN_DATA    (in_data),
        .IN_VALID   (in_valid),
        .IN_READY   (in_ready),
        .SINK_MASK  (mask),
        .SINK_READY (ready),
        .SEL        (sel),
        .EN         (en),
        .OUT_DATA   (out_data),
        .OUT_VALID  (out_valid),
        .BUSY       (busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the stream and how many words it has taken.
    int m_phase = P_IDLE;
    int m_sel   = 0;
    int m_last  = 3;
    int m_taken = 0;
    int src_idx = 0;
    bit run     = 1'b0;

    always @(posedge clk) begin
        if (!rstn) begin
            m_phase = P_IDLE;
            m_sel   = 0;
            m_last  = 3;
            m_taken = 0;
        end else if (m_phase == P_IDLE) begin
            if (in_valid) m_phase = P_ARB;
        end else if (m_phase == P_ARB) begin
            if (!in_valid) begin
                m_phase = P_IDLE;
            end else begin
                for (int off = 1; off <= 4; off++) begin
                    int k;
                    k = (m_last + off) % 4;
                    if (mask[k] && ready[k]) begin
                        m_sel   = k;
                        m_last  = k;
                        m_taken = 0;
                        m_phase = P_GRANT;
                        break;
                    end
                end
            end
        end else begin
            if (!mask[m_sel]) begin
                m_phase = P_ARB;
                m_taken = 0;
            end else if (in_valid && ready[m_sel]) begin
                m_taken++;
                src_idx++;
                if (m_taken == BURST) m_phase = P_ARB;
            end
        end
        run = 1'b1;
    end

    logic [7:0] dut_log [4][$];
    logic [7:0] exp_q [$];

    always @(negedge clk) begin
        logic       exp_rdy;
        logic [3:0] exp_ov;
        #2;
        if (run) begin
            exp_rdy = rstn && (m_phase == P_GRANT) && mask[m_sel] && ready[m_sel];
            exp_ov  = (rstn && (m_phase == P_GRANT) && in_valid && mask[m_sel])
                      ? (4'b0001 << m_sel) : 4'b0000;
            check("in_ready", in_ready, exp_rdy);
            check("out_valid", out_valid, exp_ov);
            check("sel", sel, m_sel);
            check("en", en, m_phase == P_GRANT);
            check("busy", busy, rstn && (m_phase != P_IDLE));
            check("out_data", out_data, in_data);
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && in_ready) dut_log[k].push_back(out_data);
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic [3:0] m, input logic [3:0] rd);
        @(negedge clk);
        rstn     = r;
        in_valid = v;
        mask     = m;
        ready    = rd;
        in_data  = DW'(src_idx);
        @(posedge clk);
        #1;
    endtask

    task automatic run_words(input int n, input logic [3:0] m, input logic [3:0] rd);
        int target;
        int cyc;
        target = src_idx + n;
        cyc = 0;
        while (src_idx < target && cyc < 64) begin
            step(1'b1, 1'b1, m, rd);
            cyc++;
        end
        check("run_words_done", src_idx >= target, 1'b1);
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 4; k++) dut_log[k].delete();
    endtask

    task automatic push_range(input int first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(8'(first + i));
    endtask

    task automatic check_log(input string name, input int k);
        check({name, "_count"}, dut_log[k].size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < dut_log[k].size(); i++) begin
            check({name, "_word"}, dut_log[k][i], exp_q[i]);
        end
        exp_q.delete();
    endtask

    initial begin
        // Reset held with traffic pending
        step(1'b0, 1'b1, 4'hF, 4'hF);
        step(1'b0, 1'b1, 4'hF, 4'hF);
        check("rst_sel", sel, 2'd0);
        check("rst_en", en, 1'b0);
        check("rst_out_valid", out_valid, 4'h0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        clear_logs();

        // Round-robin over all sinks, words 0x00..0x0B
        run_words(12, 4'hF, 4'hF);
        push_range(8'h00, 4); check_log("rr_sink0", 0);
        push_range(8'h04, 4); check_log("rr_sink1", 1);
        push_range(8'h08, 4); check_log("rr_sink2", 2);
        check_log("rr_sink3", 3);
        step(1'b1, 1'b0, 4'hF, 4'hF);
        check("idle_busy", busy, 1'b0);

        // Sparse ready: only sinks 1 and 3 are ever granted
        step(1'b0, 1'b0, 4'hF, 4'hF);
        clear_logs();
        run_words(16, 4'hF, 4'b1010);
        push_range(8'h0C, 4); push_range(8'h14, 4); check_log("sparse_sink1", 1);
        push_range(8'h10, 4); push_range(8'h18, 4); check_log("sparse_sink3", 3);
        check_log("sparse_sink0", 0);
        check_log("sparse_sink2", 2);
        step(1'b1, 1'b0, 4'hF, 4'hF);

        // Backpressure mid-burst on sink 0
        step(1'b0, 1'b0, 4'hF, 4'hF);
        clear_logs();
        run_words(2, 4'hF, 4'hF);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 4'hF, 4'b1110);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_sel", sel, 2'd0);
        end
        run_words(2, 4'hF, 4'hF);
        push_range(8'h1C, 4); check_log("bp_sink0", 0);
        check_log("bp_sink1", 1);

        // Mask drop on sink 1 after two words
        run_words(2, 4'hF, 4'hF);
        step(1'b1, 1'b1, 4'b1101, 4'hF);
        check("drop_en", en, 1'b0);
        check("drop_busy", busy, 1'b1);
        run_words(4, 4'b1101, 4'hF);
        push_range(8'h20, 2); check_log("drop_sink1", 1);
        push_range(8'h22, 4); check_log("drop_sink2", 2);
        check("drop_sel", sel, 2'd2);
        step(1'b1, 1'b0, 4'hF, 4'hF);

        // Reset in the middle of a sink 2 burst
        step(1'b0, 1'b0, 4'hF, 4'hF);
        clear_logs();
        run_words(10, 4'hF, 4'hF);
        step(1'b0, 1'b1, 4'hF, 4'hF);
        check("mrst_sel", sel, 2'd0);
        check("mrst_en", en, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_out_valid", out_valid, 4'h0);
        run_words(1, 4'hF, 4'hF);
        push_range(8'h26, 4); push_range(8'h30, 1); check_log("mrst_sink0", 0);
        push_range(8'h2E, 2); check_log("mrst_sink2", 2);
        step(1'b1, 1'b0, 4'hF, 4'hF);
        step(1'b1, 1'b0, 4'hF, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
